arc4_sched: RTL and testbench
=============================

ARC4_SCHED -- requirements
Module: arc4_sched

Interface
REQ-001 Parameter WDOG_CYCLES, default 4095: maximum cycles a phase may stay busy before it is aborted.
REQ-002 Clocking is fixed: one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  sole clock; all state updates on posedge clk.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 en  in  1  start request; sampled only while rdy=1.
REQ-006 rdy  out  1  high when idle and able to accept en.
REQ-007 key  in  24  cipher key; latched on accepted en.
REQ-008 key_q  out  24  latched key, driven to ksa/prga engines.
REQ-009 done  out  1  one-cycle pulse on successful completion of all phases.
REQ-010 err  out  1  sticky watchdog-abort flag; cleared on the next accepted en.
REQ-011 phase  out  2  active phase: 0 idle, 1 init, 2 ksa, 3 prga.
REQ-012 {init,ksa,prga}_en  out  1 each  engine start pulses.
REQ-013 {init,ksa,prga}_rdy  in  1 each  engine ready inputs.
REQ-014 {init,ksa,prga}_addr  in  8 each; {init,ksa,prga}_wrdata  in  8 each; {init,ksa,prga}_wren  in  1 each  engine S-memory requests.
REQ-015 s_addr  out  8; s_wrdata  out  8; s_wren  out  1  shared S-memory port; s_rddata passes to engines outside this block.

Function
REQ-016 FSM states SHALL be IDLE, then X_GO, X_DROP, X_WAIT for X = INIT, KSA, PRGA, in that order.
REQ-017 IDLE: rdy=1; en=1 SHALL latch key into key_q, clear err, and go to INIT_GO next cycle; rdy=0 in all other states.
REQ-018 X_GO: if x_rdy=1, assert x_en for exactly that cycle and go to X_DROP; if x_rdy=0, hold x_en=0 and remain in X_GO.
REQ-019 X_DROP: wait for x_rdy=0, then go to X_WAIT. This tolerates engines that keep rdy high for cycles after en.
REQ-020 X_WAIT: on x_rdy=1, go to the next phase's GO state; PRGA_WAIT goes to IDLE with done=1 for that one cycle.
REQ-021 Watchdog: a counter of width $clog2(WDOG_CYCLES+1) clears on entry to X_DROP and increments in X_DROP/X_WAIT.
REQ-022 Watchdog abort: when the counter reaches WDOG_CYCLES, the FSM SHALL go to IDLE with err=1 and done=0.
REQ-023 Grant: in all three states of phase X, s_addr/s_wrdata/s_wren SHALL combinationally equal X's request, with zero added latency.
REQ-024 In IDLE: s_addr=0, s_wrdata=0, s_wren=0; requests from non-granted engines SHALL be ignored.
REQ-025 At most one x_en SHALL be high in any cycle; en while rdy=0 SHALL be ignored.
REQ-026 key_q SHALL be stable from acceptance until the next accepted en; key changes mid-run have no effect.

Reset
REQ-027 rst=1 at any clock, including mid-phase, SHALL force state=IDLE and phase=0.
REQ-028 Reset values: rdy=1, done=0, err=0, key_q=0, all x_en=0, watchdog=0, s_wren=0, s_addr=0, s_wrdata=0.

Structure
REQ-029 Package arc4_pkg SHALL hold the FSM state enum, the phase encoding constants and the 24-bit key width constant.
REQ-030 Sub-module s_mem_mux SHALL be purely combinational, selecting the S-memory port by phase; arc4_sched owns the FSM, watchdog and key latch.

Verification
REQ-031 Reset check: assert rst, then release -> rdy=1, phase=0, s_wren=0, err=0, key_q=0.
REQ-032 Full run: stub engines hold rdy=1 for 1 cycle after en, then busy for 256/768/300 cycles; en=1, key=24'h00033C -> init_en, ksa_en, prga_en each pulse once in order, key_q=24'h00033C, done pulses once, rdy returns to 1.
REQ-033 Grant: during the ksa phase, init drives wren=1/addr=8'h55 -> s_wren and s_addr follow ksa only; in IDLE, s_wren=0.
REQ-034 Hold-off: ksa_rdy=0 on entry to KSA_GO for 5 cycles -> ksa_en stays 0, then pulses once in the cycle ksa_rdy=1.
REQ-035 Watchdog: WDOG_CYCLES=16, prga stub never returns rdy -> after 16 cycles in PRGA_DROP/PRGA_WAIT, FSM goes to IDLE with err=1 and no done; the next en clears err.
REQ-036 Robustness: rst during KSA_WAIT -> IDLE next cycle with all x_en=0 and s_wren=0; en and key changes during busy phases are ignored.

Source files
------------

// File: rtl/arc4_pkg.sv
// Shared types and constants for the ARC4 phase scheduler.
// Holds the FSM state enum, the phase encoding and the key width.
package arc4_pkg;

  localparam int unsigned KeyW = 24;

  localparam logic [1:0] PhIdle = 2'd0;
  localparam logic [1:0] PhInit = 2'd1;
  localparam logic [1:0] PhKsa  = 2'd2;
  localparam logic [1:0] PhPrga = 2'd3;

  typedef enum logic [3:0] {
    StIdle,
    StInitGo,
    StInitDrop,
    StInitWait,
    StKsaGo,
    StKsaDrop,
    StKsaWait,
    StPrgaGo,
    StPrgaDrop,
    StPrgaWait
  } arc4_state_e;

  function automatic logic [1:0] state_phase(input arc4_state_e s);
    case (s)
      StInitGo, StInitDrop, StInitWait: return PhInit;
      StKsaGo, StKsaDrop, StKsaWait:    return PhKsa;
      StPrgaGo, StPrgaDrop, StPrgaWait: return PhPrga;
      default:                          return PhIdle;
    endcase
  endfunction

endpackage

// File: rtl/s_mem_mux.sv
// Combinational S-memory port select: the engine owning the active phase drives the port.
// In idle the port is held quiet.
module s_mem_mux
  import arc4_pkg::*;
(
  input  logic [1:0] phase,
  input  logic [7:0] init_addr,
  input  logic [7:0] init_wrdata,
  input  logic       init_wren,
  input  logic [7:0] ksa_addr,
  input  logic [7:0] ksa_wrdata,
  input  logic       ksa_wren,
  input  logic [7:0] prga_addr,
  input  logic [7:0] prga_wrdata,
  input  logic       prga_wren,
  output logic [7:0] s_addr,
  output logic [7:0] s_wrdata,
  output logic       s_wren
);

  always_comb begin
    s_addr   = '0;
    s_wrdata = '0;
    s_wren   = 1'b0;
    case (phase)
      PhInit: begin
        s_addr   = init_addr;
        s_wrdata = init_wrdata;
        s_wren   = init_wren;
      end
      PhKsa: begin
        s_addr   = ksa_addr;
        s_wrdata = ksa_wrdata;
        s_wren   = ksa_wren;
      end
      PhPrga: begin
        s_addr   = prga_addr;
        s_wrdata = prga_wrdata;
        s_wren   = prga_wren;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/arc4_sched.sv
// ARC4 phase scheduler: sequences init, ksa and prga engines with a per-phase watchdog,
// latches the key and grants the shared S-memory port to the active engine.
module arc4_sched
  import arc4_pkg::*;
#(
  parameter int unsigned WDOG_CYCLES = 4095
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  output logic            rdy,
  input  logic [KeyW-1:0] key,
  output logic [KeyW-1:0] key_q,
  output logic            done,
  output logic            err,
  output logic [1:0]      phase,
  output logic            init_en,
  output logic            ksa_en,
  output logic            prga_en,
  input  logic            init_rdy,
  input  logic            ksa_rdy,
  input  logic            prga_rdy,
  input  logic [7:0]      init_addr,
  input  logic [7:0]      init_wrdata,
  input  logic            init_wren,
  input  logic [7:0]      ksa_addr,
  input  logic [7:0]      ksa_wrdata,
  input  logic            ksa_wren,
  input  logic [7:0]      prga_addr,
  input  logic [7:0]      prga_wrdata,
  input  logic            prga_wren,
  output logic [7:0]      s_addr,
  output logic [7:0]      s_wrdata,
  output logic            s_wren
);

  localparam int unsigned WdW = $clog2(WDOG_CYCLES + 1);
  localparam logic [WdW-1:0] WdLast = WdW'(WDOG_CYCLES - 1);

  arc4_state_e    state_q;
  arc4_state_e    wait_st;
  arc4_state_e    next_go;
  logic [WdW-1:0] wd_q;
  logic           cur_rdy;

  assign phase   = state_phase(state_q);
  assign rdy     = (state_q == StIdle);
  // Start pulses are Mealy so the engine sees en in the very cycle it reports ready.
  assign init_en = (state_q == StInitGo) && init_rdy;
  assign ksa_en  = (state_q == StKsaGo) && ksa_rdy;
  assign prga_en = (state_q == StPrgaGo) && prga_rdy;

  always_comb begin
    cur_rdy = 1'b0;
    wait_st = StIdle;
    next_go = StIdle;
    case (phase)
      PhInit: begin
        cur_rdy = init_rdy;
        wait_st = StInitWait;
        next_go = StKsaGo;
      end
      PhKsa: begin
        cur_rdy = ksa_rdy;
        wait_st = StKsaWait;
        next_go = StPrgaGo;
      end
      PhPrga: begin
        cur_rdy = prga_rdy;
        wait_st = StPrgaWait;
        next_go = StIdle;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      key_q   <= '0;
      err     <= 1'b0;
      done    <= 1'b0;
      wd_q    <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (en) begin
            key_q   <= key;
            err     <= 1'b0;
            state_q <= StInitGo;
          end
        end
        StInitGo, StKsaGo, StPrgaGo: begin
          if (cur_rdy) begin
            state_q <= arc4_state_e'(state_q + 4'd1);
            wd_q    <= '0;
          end
        end
        StInitDrop, StKsaDrop, StPrgaDrop: begin
          if (wd_q == WdLast) begin
            state_q <= StIdle;
            err     <= 1'b1;
            wd_q    <= '0;
          end else begin
            wd_q <= wd_q + WdW'(1);
            if (!cur_rdy) state_q <= wait_st;
          end
        end
        StInitWait, StKsaWait, StPrgaWait: begin
          // Completion wins over an abort landing in the same cycle.
          if (cur_rdy) begin
            state_q <= next_go;
            done    <= (phase == PhPrga);
          end else if (wd_q == WdLast) begin
            state_q <= StIdle;
            err     <= 1'b1;
            wd_q    <= '0;
          end else begin
            wd_q <= wd_q + WdW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  s_mem_mux u_s_mem_mux (
    .phase       (phase),
    .init_addr   (init_addr),
    .init_wrdata (init_wrdata),
    .init_wren   (init_wren),
    .ksa_addr    (ksa_addr),
    .ksa_wrdata  (ksa_wrdata),
    .ksa_wren    (ksa_wren),
    .prga_addr   (prga_addr),
    .prga_wrdata (prga_wrdata),
    .prga_wren   (prga_wren),
    .s_addr      (s_addr),
    .s_wrdata    (s_wrdata),
    .s_wren      (s_wren)
  );

endmodule

// File: tb/tb_arc4_sched.sv
// Directed bench for arc4_sched: a default-watchdog instance runs full sequences against
// stub engines, a WDOG_CYCLES=16 instance exercises the watchdog abort.
module tb_arc4_sched;

  logic        clk = 1'b0;
  logic        rst, en, en_wd;
  logic [23:0] key;
  logic [7:0]  init_addr, init_wrdata, ksa_addr, ksa_wrdata, prga_addr, prga_wrdata;
  logic        init_wren, ksa_wren, prga_wren;

  logic        rdy, done, err, init_en, ksa_en, prga_en, s_wren;
  logic [23:0] key_q;
  logic [1:0]  phase;
  logic [7:0]  s_addr, s_wrdata;

  logic        wd_rdy, wd_done, wd_err, wd_init_en, wd_ksa_en, wd_prga_en, wd_s_wren;
  logic [23:0] wd_key_q;
  logic [1:0]  wd_phase;
  logic [7:0]  wd_s_addr, wd_s_wrdata;

  // Stub engines: 0..2 serve dut, 3..5 serve dut_wd.
  logic [5:0] eng_en, eng_rdy, hold, hang;
  int         busy_len [6];
  logic [1:0] st [6];
  int         cnt [6];

  int checks = 0, failures = 0;
  int cyc = 0, init_cnt = 0, ksa_cnt = 0, prga_cnt = 0, done_cnt = 0, multi_en = 0;
  int init_cyc = 0, ksa_cyc = 0, prga_cyc = 0, wd_done_cnt = 0, wd_ph3_cnt = 0;

  always #5 clk = ~clk;

  arc4_sched dut (
    .clk(clk), .rst(rst), .en(en), .rdy(rdy), .key(key), .key_q(key_q), .done(done),
    .err(err), .phase(phase), .init_en(init_en), .ksa_en(ksa_en), .prga_en(prga_en),
    .init_rdy(eng_rdy[0]), .ksa_rdy(eng_rdy[1]), .prga_rdy(eng_rdy[2]),
    .init_addr(init_addr), .init_wrdata(init_wrdata), .init_wren(init_wren),
    .ksa_addr(ksa_addr), .ksa_wrdata(ksa_wrdata), .ksa_wren(ksa_wren),
    .prga_addr(prga_addr), .prga_wrdata(prga_wrdata), .prga_wren(prga_wren),
    .s_addr(s_addr), .s_wrdata(s_wrdata), .s_wren(s_wren)
  );

  arc4_sched #(.WDOG_CYCLES(16)) dut_wd (
    .clk(clk), .rst(rst), .en(en_wd), .rdy(wd_rdy), .key(24'h123456), .key_q(wd_key_q),
    .done(wd_done), .err(wd_err), .phase(wd_phase), .init_en(wd_init_en),
    .ksa_en(wd_ksa_en), .prga_en(wd_prga_en),
    .init_rdy(eng_rdy[3]), .ksa_rdy(eng_rdy[4]), .prga_rdy(eng_rdy[5]),
    .init_addr(8'h00), .init_wrdata(8'h00), .init_wren(1'b0),
    .ksa_addr(8'h00), .ksa_wrdata(8'h00), .ksa_wren(1'b0),
    .prga_addr(8'h00), .prga_wrdata(8'h00), .prga_wren(1'b0),
    .s_addr(wd_s_addr), .s_wrdata(wd_s_wrdata), .s_wren(wd_s_wren)
  );

  assign eng_en = {wd_prga_en, wd_ksa_en, wd_init_en, prga_en, ksa_en, init_en};

  always_comb begin
    eng_rdy = '0;
    for (int i = 0; i < 6; i++) eng_rdy[i] = (st[i] != 2'd2) && !hold[i];
  end

  // Stub: ready, linger one cycle after en, busy busy_len cycles (or forever if hang).
  always @(posedge clk) begin
    for (int i = 0; i < 6; i++) begin
      if (rst) begin
        st[i]  <= 2'd0;
        cnt[i] <= 0;
      end else begin
        case (st[i])
          2'd0: if (eng_en[i]) st[i] <= 2'd1;
          2'd1: begin st[i] <= 2'd2; cnt[i] <= busy_len[i]; end
          default: if (!hang[i]) begin
            if (cnt[i] <= 1) st[i] <= 2'd0;
            else cnt[i] <= cnt[i] - 1;
          end
        endcase
      end
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (init_en) begin init_cnt <= init_cnt + 1; init_cyc <= cyc; end
    if (ksa_en) begin ksa_cnt <= ksa_cnt + 1; ksa_cyc <= cyc; end
    if (prga_en) begin prga_cnt <= prga_cnt + 1; prga_cyc <= cyc; end
    if (done) done_cnt <= done_cnt + 1;
    if (wd_done) wd_done_cnt <= wd_done_cnt + 1;
    if (wd_phase == 2'd3 && !wd_prga_en) wd_ph3_cnt <= wd_ph3_cnt + 1;
    if ($countones({init_en, ksa_en, prga_en}) > 1 ||
        $countones({wd_init_en, wd_ksa_en, wd_prga_en}) > 1) multi_en <= multi_en + 1;
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL reset_rdy got %b want 1", rdy); end
    checks++; if (phase !== 2'd0) begin failures++; $display("FAIL reset_phase got %0d want 0", phase); end
    checks++; if (s_wren !== 1'b0) begin failures++; $display("FAIL reset_s_wren got %b want 0", s_wren); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got %b want 0", err); end
    checks++; if (key_q !== 24'h0) begin failures++; $display("FAIL reset_key_q got %h want 000000", key_q); end
    checks++; if ({done, init_en, ksa_en, prga_en} !== 4'b0) begin
      failures++; $display("FAIL reset_pulses got %b want 0000", {done, init_en, ksa_en, prga_en});
    end
  endtask

  task automatic test_run_start();
    hold[1] = 1'b1;
    @(negedge clk);
    en = 1'b1; key = 24'h00033C;
    @(negedge clk);
    en = 1'b0;
    checks++; if (key_q !== 24'h00033C) begin failures++; $display("FAIL start_key_q got %h want 00033c", key_q); end
    checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL start_rdy got %b want 0", rdy); end
    checks++; if (phase !== 2'd1) begin failures++; $display("FAIL start_phase got %0d want 1", phase); end
    checks++; if (init_en !== 1'b1) begin failures++; $display("FAIL start_init_en got %b want 1", init_en); end
  endtask

  task automatic test_hold_off();
    bit seen = 1'b0;
    for (int k = 0; k < 1000 && !seen; k++) begin
      @(negedge clk);
      seen = (phase == 2'd2);
    end
    checks++; if (!seen) begin failures++; $display("FAIL holdoff_ksa_phase got timeout want phase 2"); end
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      checks++; if (ksa_en !== 1'b0 || phase !== 2'd2) begin
        failures++; $display("FAIL holdoff_en_low cycle %0d got en=%b phase=%0d want en=0 phase=2", k, ksa_en, phase);
      end
    end
    @(negedge clk);
    hold[1] = 1'b0;
    #1;
    checks++; if (ksa_en !== 1'b1) begin failures++; $display("FAIL holdoff_pulse got %b want 1", ksa_en); end
    @(negedge clk);
    checks++; if (ksa_en !== 1'b0) begin failures++; $display("FAIL holdoff_single got %b want 0", ksa_en); end
    checks++; if (ksa_cnt !== 1) begin failures++; $display("FAIL holdoff_count got %0d want 1", ksa_cnt); end
  endtask

  task automatic test_grant();
    init_wren = 1'b1; init_addr = 8'h55; init_wrdata = 8'hA1;
    ksa_wren  = 1'b0; ksa_addr  = 8'h12; ksa_wrdata  = 8'hB2;
    #1;
    checks++; if (s_wren !== 1'b0) begin failures++; $display("FAIL grant_ksa_wren0 got %b want 0", s_wren); end
    checks++; if (s_addr !== 8'h12) begin failures++; $display("FAIL grant_ksa_addr got %h want 12", s_addr); end
    checks++; if (s_wrdata !== 8'hB2) begin failures++; $display("FAIL grant_ksa_data got %h want b2", s_wrdata); end
    ksa_wren = 1'b1;
    #1;
    checks++; if (s_wren !== 1'b1) begin failures++; $display("FAIL grant_ksa_wren1 got %b want 1", s_wren); end
    en = 1'b1; key = 24'hFFFFFF;
    repeat (3) @(negedge clk);
    en = 1'b0;
    checks++; if (key_q !== 24'h00033C) begin failures++; $display("FAIL busy_key_q got %h want 00033c", key_q); end
    checks++; if (rdy !== 1'b0 || phase !== 2'd2) begin
      failures++; $display("FAIL busy_en_ignored got rdy=%b phase=%0d want rdy=0 phase=2", rdy, phase);
    end
    checks++; if (init_cnt !== 1) begin failures++; $display("FAIL busy_init_count got %0d want 1", init_cnt); end
  endtask

  task automatic test_run_complete();
    bit seen = 1'b0;
    prga_wren = 1'b1; prga_addr = 8'h7E; prga_wrdata = 8'hC3;
    for (int k = 0; k < 2000 && !seen; k++) begin
      @(negedge clk);
      seen = (phase == 2'd3);
    end
    checks++; if (!seen) begin failures++; $display("FAIL run_prga_phase got timeout want phase 3"); end
    checks++; if (s_addr !== 8'h7E || s_wren !== 1'b1) begin
      failures++; $display("FAIL grant_prga got addr=%h wren=%b want 7e 1", s_addr, s_wren);
    end
    seen = 1'b0;
    for (int k = 0; k < 1000 && !seen; k++) begin
      @(negedge clk);
      seen = (done === 1'b1);
    end
    checks++; if (!seen) begin failures++; $display("FAIL run_done got timeout want done pulse"); end
    checks++; if (rdy !== 1'b1 || phase !== 2'd0) begin
      failures++; $display("FAIL run_idle got rdy=%b phase=%0d want 1 0", rdy, phase);
    end
    @(negedge clk);
    checks++; if (done !== 1'b0 || done_cnt !== 1) begin
      failures++; $display("FAIL run_done_once got done=%b count=%0d want 0 1", done, done_cnt);
    end
    checks++; if (init_cnt !== 1 || ksa_cnt !== 1 || prga_cnt !== 1) begin
      failures++; $display("FAIL run_en_counts got %0d/%0d/%0d want 1/1/1", init_cnt, ksa_cnt, prga_cnt);
    end
    checks++; if (!(init_cyc < ksa_cyc && ksa_cyc < prga_cyc)) begin
      failures++; $display("FAIL run_en_order got %0d/%0d/%0d want increasing", init_cyc, ksa_cyc, prga_cyc);
    end
    checks++; if (err !== 1'b0 || key_q !== 24'h00033C) begin
      failures++; $display("FAIL run_end_state got err=%b key_q=%h want 0 00033c", err, key_q);
    end
  endtask

  task automatic test_idle_grant();
    #1;
    checks++; if (s_wren !== 1'b0 || s_addr !== 8'h00 || s_wrdata !== 8'h00) begin
      failures++; $display("FAIL idle_grant got wren=%b addr=%h data=%h want 0 00 00", s_wren, s_addr, s_wrdata);
    end
  endtask

  task automatic test_watchdog();
    bit seen = 1'b0;
    @(negedge clk);
    en_wd = 1'b1;
    @(negedge clk);
    en_wd = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clk);
      seen = (wd_rdy === 1'b1);
    end
    checks++; if (!seen) begin failures++; $display("FAIL wdog_return got timeout want rdy=1"); end
    checks++; if (wd_err !== 1'b1) begin failures++; $display("FAIL wdog_err got %b want 1", wd_err); end
    checks++; if (wd_done_cnt !== 0) begin failures++; $display("FAIL wdog_no_done got %0d want 0", wd_done_cnt); end
    checks++; if (wd_ph3_cnt !== 16) begin failures++; $display("FAIL wdog_cycles got %0d want 16", wd_ph3_cnt); end
    en_wd = 1'b1;
    @(negedge clk);
    en_wd = 1'b0;
    checks++; if (wd_err !== 1'b0 || wd_rdy !== 1'b0) begin
      failures++; $display("FAIL wdog_err_clear got err=%b rdy=%b want 0 0", wd_err, wd_rdy);
    end
  endtask

  task automatic test_reset_mid_phase();
    bit seen = 1'b0;
    @(negedge clk);
    en = 1'b1; key = 24'h0ABCDE;
    @(negedge clk);
    en = 1'b0;
    for (int k = 0; k < 1000 && !seen; k++) begin
      @(negedge clk);
      seen = (phase == 2'd2) && (eng_rdy[1] == 1'b0);
    end
    @(negedge clk);
    checks++; if (!seen || phase !== 2'd2 || s_wren !== 1'b1) begin
      failures++; $display("FAIL midrst_ksa_wait got seen=%b phase=%0d wren=%b want 1 2 1", seen, phase, s_wren);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (phase !== 2'd0 || rdy !== 1'b1) begin
      failures++; $display("FAIL midrst_idle got phase=%0d rdy=%b want 0 1", phase, rdy);
    end
    checks++; if ({init_en, ksa_en, prga_en, s_wren} !== 4'b0) begin
      failures++; $display("FAIL midrst_quiet got %b want 0000", {init_en, ksa_en, prga_en, s_wren});
    end
    checks++; if (key_q !== 24'h0 || done !== 1'b0) begin
      failures++; $display("FAIL midrst_regs got key_q=%h done=%b want 000000 0", key_q, done);
    end
    checks++; if (multi_en !== 0) begin failures++; $display("FAIL en_onehot got %0d want 0", multi_en); end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; en_wd = 1'b0; key = 24'h0;
    init_addr = 8'h00; init_wrdata = 8'h00; init_wren = 1'b0;
    ksa_addr = 8'h00; ksa_wrdata = 8'h00; ksa_wren = 1'b0;
    prga_addr = 8'h00; prga_wrdata = 8'h00; prga_wren = 1'b0;
    hold = '0; hang = 6'b100000;
    busy_len = '{256, 768, 300, 3, 3, 3};
    test_reset();
    test_run_start();
    test_hold_off();
    test_grant();
    test_run_complete();
    test_idle_grant();
    test_watchdog();
    test_reset_mid_phase();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
